// File: rtl/standard_7448.sv
// rtl/standard_7448.sv - registered BCD-to-seven-segment decoder with LT/RBI/BI controls
// Define STANDARD_7448_HEX_EN to replace the 7448 glyphs for codes 10-15 (and 6/9) with hex glyphs.
module standard_7448 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       LT,
  input  logic       RBI,
  input  logic       BI,
  output logic [6:0] display,
  output logic       RBO
);

  logic [6:0] glyph;
  logic [6:0] display_d, display_q;
  logic       rbo_d, rbo_q;

  // Segment order is abcdefg, a in bit 6.
  always_comb begin
    glyph = 7'b0000000;
    case (data)
      4'd0:  glyph = 7'b1111110;
      4'd1:  glyph = 7'b0110000;
      4'd2:  glyph = 7'b1101101;
      4'd3:  glyph = 7'b1111001;
      4'd4:  glyph = 7'b0110011;
      4'd5:  glyph = 7'b1011011;
      4'd7:  glyph = 7'b1110000;
      4'd8:  glyph = 7'b1111111;
`ifdef STANDARD_7448_HEX_EN
      4'd6:  glyph = 7'b1011111;
      4'd9:  glyph = 7'b1111011;
      4'd10: glyph = 7'b1110111;
      4'd11: glyph = 7'b0011111;
      4'd12: glyph = 7'b1001110;
      4'd13: glyph = 7'b0111101;
      4'd14: glyph = 7'b1001111;
      4'd15: glyph = 7'b1000111;
`else
      4'd6:  glyph = 7'b0011111;
      4'd9:  glyph = 7'b1110011;
      4'd10: glyph = 7'b0001101;
      4'd11: glyph = 7'b0011001;
      4'd12: glyph = 7'b0100011;
      4'd13: glyph = 7'b1001011;
      4'd14: glyph = 7'b0001111;
      4'd15: glyph = 7'b0000000;
`endif
      default: glyph = 7'b0000000;
    endcase
  end

  // BI beats LT beats ripple blanking beats the decoded digit.
  always_comb begin
    display_d = glyph;
    rbo_d     = 1'b0;
    if (BI) begin
      display_d = 7'b0000000;
    end else if (LT) begin
      display_d = 7'b1111111;
    end else if (RBI && (data == 4'd0)) begin
      display_d = 7'b0000000;
      rbo_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_q <= 7'b0000000;
      rbo_q     <= 1'b0;
    end else begin
      display_q <= display_d;
      rbo_q     <= rbo_d;
    end
  end

  assign display = display_q;
  assign RBO     = rbo_q;

endmodule

// File: tb/tb_standard_7448.sv
// tb/tb_standard_7448.sv - scoreboard bench for standard_7448, including a two-digit RBI/RBO chain
module tb_standard_7448;

  typedef struct {
    logic [6:0] disp;
    logic       rbo;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] data;
  logic       lt, rbi, bi;
  logic [6:0] display;
  logic       rbo;

  logic [3:0] cu_data, cl_data;
  logic [6:0] cu_display, cl_display;
  logic       cu_rbo, cl_rbo;

  exp_t q_main[$];
  exp_t q_up[$];
  exp_t q_lo[$];

  int tests_run;
  int tests_failed;
  logic [6:0] glyph [16];

  standard_7448 dut (
    .clk(clk), .rst_n(rst_n), .data(data), .LT(lt), .RBI(rbi), .BI(bi),
    .display(display), .RBO(rbo)
  );

  standard_7448 u_upper (
    .clk(clk), .rst_n(rst_n), .data(cu_data), .LT(1'b0), .RBI(1'b1), .BI(1'b0),
    .display(cu_display), .RBO(cu_rbo)
  );

  standard_7448 u_lower (
    .clk(clk), .rst_n(rst_n), .data(cl_data), .LT(1'b0), .RBI(cu_rbo), .BI(1'b0),
    .display(cl_display), .RBO(cl_rbo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [6:0] got_d, input logic got_r,
                       input logic [6:0] exp_d, input logic exp_r);
    tests_run++;
    if (got_d !== exp_d || got_r !== exp_r) begin
      tests_failed++;
      $display("FAIL %s: got display=%b RBO=%b, expected display=%b RBO=%b",
               name, got_d, got_r, exp_d, exp_r);
    end
  endtask

  // Monitor: outputs are valid every cycle, one edge after the stimulus was pushed.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q_main.size() > 0) begin
      e = q_main.pop_front();
      check(e.name, display, rbo, e.disp, e.rbo);
    end
    if (q_up.size() > 0) begin
      e = q_up.pop_front();
      check(e.name, cu_display, cu_rbo, e.disp, e.rbo);
    end
    if (q_lo.size() > 0) begin
      e = q_lo.pop_front();
      check(e.name, cl_display, cl_rbo, e.disp, e.rbo);
    end
  end

  task automatic drive(input logic [3:0] d, input logic l, input logic r, input logic b,
                       input logic [6:0] exp_d, input logic exp_r, input string name);
    exp_t e;
    @(negedge clk);
    data = d;
    lt   = l;
    rbi  = r;
    bi   = b;
    e.disp = exp_d;
    e.rbo  = exp_r;
    e.name = name;
    q_main.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_main.size() + q_up.size() + q_lo.size()) > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if ((q_main.size() + q_up.size() + q_lo.size()) > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected responses never observed, required 0",
               q_main.size() + q_up.size() + q_lo.size());
    end
  endtask

  initial begin
    exp_t e;
    tests_run    = 0;
    tests_failed = 0;
`ifdef STANDARD_7448_HEX_EN
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`else
    glyph = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
              7'b1111111, 7'b1110011, 7'b0001101, 7'b0011001,
              7'b0100011, 7'b1001011, 7'b0001111, 7'b0000000};
`endif

    rst_n   = 1'b0;
    data    = 4'd8;
    lt      = 1'b1;
    rbi     = 1'b0;
    bi      = 1'b0;
    cu_data = 4'd5;
    cl_data = 4'd0;

    #2;
    check("reset_async", display, rbo, 7'b0000000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd8, 1'b1, 1'b0, 1'b0, 7'b1111111, 1'b0, "reset_release_lt");

    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 1'b0, 1'b0, glyph[i], 1'b0, $sformatf("sweep_%0d", i));
    end

    drive(4'd3, 1'b1, 1'b1, 1'b0, 7'b1111111, 1'b0, "lamp_test");
    drive(4'd0, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b1, "ripple_blank_zero");
    drive(4'd5, 1'b0, 1'b1, 1'b0, 7'b1011011, 1'b0, "ripple_nonzero");
    drive(4'd2, 1'b1, 1'b1, 1'b1, 7'b0000000, 1'b0, "bi_priority");
    drive(4'd2, 1'b1, 1'b1, 1'b0, 7'b1111111, 1'b0, "bi_drop_lt");
    drive(4'd8, 1'b0, 1'b0, 1'b1, 7'b0000000, 1'b0, "bi_only");
    drive(4'd0, 1'b0, 1'b0, 1'b0, 7'b1111110, 1'b0, "zero_no_rbi");
    drive(4'd0, 1'b1, 1'b1, 1'b0, 7'b1111111, 1'b0, "lt_over_ripple");
    drive(4'd0, 1'b0, 1'b1, 1'b0, 7'b0000000, 1'b1, "ripple_again");
    drain();

    // Asynchronous reset in the middle of a cycle, with RBO high beforehand.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", display, rbo, 7'b0000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 1'b0, 1'b0, 1'b0, glyph[4], 1'b0, "after_mid_reset");
    drain();

    // Chain: upper held at 5 so its RBO starts low, then both digits go to 0.
    @(negedge clk);
    cu_data = 4'd0;
    e.disp = 7'b0000000; e.rbo = 1'b1; e.name = "chain_upper_c1"; q_up.push_back(e);
    e.disp = 7'b1111110; e.rbo = 1'b0; e.name = "chain_lower_c1"; q_lo.push_back(e);
    @(negedge clk);
    e.disp = 7'b0000000; e.rbo = 1'b1; e.name = "chain_upper_c2"; q_up.push_back(e);
    e.disp = 7'b0000000; e.rbo = 1'b1; e.name = "chain_lower_c2"; q_lo.push_back(e);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
